vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the pixel clock produced by the clock-divider stage, which sits directly upstream. It keeps horizontal and vertical position counters and produces registered sync, blanking and pixel-coordinate outputs. The pixel-drawing logic and the board VGA pins sit downstream and consume these outputs.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk_in  in  1  pixel clock from the divider stage; all logic on its rising edge
- reset  in  1  asynchronous, active-high
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high while (pixel_x, pixel_y) is in the visible area
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1
- frame_start  out  1  one-cycle pulse at position (0,0)
- line_end  out  1  one-cycle pulse at pixel_x = H_TOTAL-1

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525). Both totals must be at most 1024. Counters are 10-bit unsigned.
- Two states: HOLD and RUN.
  - HOLD is entered asynchronously while reset is high.
  - The first rising edge after reset falls moves the block to RUN at position (0,0).
- Outputs in HOLD:
  - pixel_x = 0, pixel_y = 0
  - hsync = vsync = ~SYNC_POL (deasserted)
  - video_on = 0, frame_start = 0, line_end = 0
- Counter behaviour in RUN:
  - pixel_x increments every cycle.
  - At H_TOTAL-1, pixel_x wraps to 0 and pixel_y increments.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
- Sync decode:
  - hsync = SYNC_POL when pixel_x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 656..751); otherwise ~SYNC_POL.
  - vsync = SYNC_POL when pixel_y is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (default 490..491), for the whole line; otherwise ~SYNC_POL.
- video_on = (pixel_x < H_ACTIVE) && (pixel_y < V_ACTIVE).
- Pulses:
  - frame_start is high exactly when pixel_x = 0 and pixel_y = 0 in RUN.
  - line_end is high exactly when pixel_x = H_TOTAL-1 in RUN.
- Reset mid-frame: all outputs go to their HOLD values immediately, without waiting for a clock edge. After release, the frame restarts at (0,0) with frame_start = 1. No partial-frame state is retained.

## Timing
- All outputs are registered. Decoded outputs are computed from the next-state counter values, so hsync, vsync, video_on, frame_start and line_end always refer to the pixel_x/pixel_y shown in the same cycle. There is zero-cycle skew between coordinates and decode.
- Reset release to first active output: 1 clock edge. On that edge, pixel_x = 0, pixel_y = 0, video_on = 1 and frame_start = 1.
- Line period: H_TOTAL cycles (800). Frame period: H_TOTAL × V_TOTAL cycles (420000).
- hsync pulse: H_SYNC consecutive cycles per line (96).
- vsync pulse: V_SYNC × H_TOTAL consecutive cycles (1600). It starts on the cycle where pixel_x = 0 and pixel_y = 490.
- No outputs depend combinationally on inputs.

## Test plan
- **Reset values.** Hold reset high for 5 cycles, then release. Required:
  - Every output equals its HOLD value while reset is high.
  - On the first edge after release, pixel_x = 0, pixel_y = 0, video_on = 1, frame_start = 1.
- **Horizontal line.** Run one line. Required:
  - video_on is high for cycles 0..639.
  - hsync is low for exactly 96 cycles, starting at pixel_x = 656.
  - line_end is high only at pixel_x = 799.
  - pixel_x wraps 799 -> 0 while pixel_y goes 0 -> 1.
- **Vertical timing.** Run a full frame. Required:
  - vsync is low for exactly 1600 cycles, starting at (0, 490).
  - video_on is 0 for all lines 480..524.
  - Counters wrap (799, 524) -> (0, 0) with frame_start = 1.
- **Frame rate.** Run 3 frames. Required: consecutive frame_start pulses are exactly 420000 cycles apart, and there are exactly 525 line_end pulses per frame.
- **Reset mid-frame.** Assert reset asynchronously (between clock edges) at (300, 200). Required:
  - Outputs reach their HOLD values before the next clock edge.
  - After release, the next frame_start follows 1 edge later, and the following frame_start follows after 420000 more cycles.
- **Polarity.** Instantiate with SYNC_POL = 1 and run one frame. Required:
  - The sync pulse windows are unchanged but inverted.
  - hsync and vsync idle low in HOLD and outside their pulse windows.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : 640x480@60 VGA raster timing. Holds position counters and
//             registered sync, blanking and coordinate outputs.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       clk_in,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start,
    output logic       line_end
);

    localparam int unsigned c_H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned c_V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  c_H_MAX      = 10'(c_H_TOTAL - 1);
    localparam logic [9:0]  c_V_MAX      = 10'(c_V_TOTAL - 1);
    localparam logic [9:0]  c_H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  c_V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  c_HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  c_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  c_VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  c_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (c_H_TOTAL > 1024 || c_V_TOTAL > 1024) begin : g_total_check
        $error("vga_timing_gen: H/V totals must not exceed 1024");
    end

    typedef enum logic [0:0] {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;
    logic       w_hs_nxt;
    logic       w_vs_nxt;
    logic       w_von_nxt;
    logic       w_fs_nxt;
    logic       w_le_nxt;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state <= S_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Any edge outside reset runs; HOLD only yields the (0,0) start point.
    always_comb begin
        w_state_nxt = S_RUN;
        w_x_nxt     = '0;
        w_y_nxt     = '0;
        if (r_state == S_RUN) begin
            if (r_x == c_H_MAX) begin
                w_x_nxt = '0;
                w_y_nxt = (r_y == c_V_MAX) ? 10'd0 : r_y + 10'd1;
            end else begin
                w_x_nxt = r_x + 10'd1;
                w_y_nxt = r_y;
            end
        end
    end

    // Decode from next-state counters so registered flags line up with coordinates.
    always_comb begin
        w_hs_nxt  = ((w_x_nxt >= c_HS_START) && (w_x_nxt <= c_HS_END)) ? SYNC_POL : ~SYNC_POL;
        w_vs_nxt  = ((w_y_nxt >= c_VS_START) && (w_y_nxt <= c_VS_END)) ? SYNC_POL : ~SYNC_POL;
        w_von_nxt = (w_x_nxt < c_H_ACT) && (w_y_nxt < c_V_ACT);
        w_fs_nxt  = (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
        w_le_nxt  = (w_x_nxt == c_H_MAX);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_x         <= '0;
            r_y         <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
        end else begin
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            hsync       <= w_hs_nxt;
            vsync       <= w_vs_nxt;
            video_on    <= w_von_nxt;
            frame_start <= w_fs_nxt;
            line_end    <= w_le_nxt;
        end
    end

    assign pixel_x = r_x;
    assign pixel_y = r_y;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Scoreboard bench for vga_timing_gen: default-size, reduced-size
//             and inverted-polarity instances on one clock and reset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
        logic       le;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       d_hs, d_vs, d_von, d_fs, d_le;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_von, s_fs, s_le;
    logic [9:0] s_x, s_y;
    logic       p_hs, p_vs, p_von, p_fs, p_le;
    logic [9:0] p_x, p_y;

    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .clk_in(clk), .reset(reset), .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
        .pixel_x(d_x), .pixel_y(d_y), .frame_start(d_fs), .line_end(d_le)
    );

    // Reduced raster: 32 x 19, hsync 20..25, vsync lines 14..15, frame 608 cycles.
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
    ) u_small (
        .clk_in(clk), .reset(reset), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
        .pixel_x(s_x), .pixel_y(s_y), .frame_start(s_fs), .line_end(s_le)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
    ) u_pol (
        .clk_in(clk), .reset(reset), .hsync(p_hs), .vsync(p_vs), .video_on(p_von),
        .pixel_x(p_x), .pixel_y(p_y), .frame_start(p_fs), .line_end(p_le)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t q_d[$];
    exp_t q_s[$];
    exp_t q_p[$];

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    // n < 0 means HOLD; otherwise n is the number of edges since reset release.
    function automatic exp_t model(input int n, input int ha, input int hf, input int hsw,
                                   input int hb, input int va, input int vf, input int vsw,
                                   input int vb, input logic pol);
        exp_t e;
        int   ht, vt, f, x, y;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (n < 0) begin
            e = '{x: 10'd0, y: 10'd0, hs: ~pol, vs: ~pol, von: 1'b0, fs: 1'b0, le: 1'b0};
        end else begin
            f     = n % (ht * vt);
            x     = f % ht;
            y     = f / ht;
            e.x   = 10'(x);
            e.y   = 10'(y);
            e.hs  = (x >= ha + hf && x < ha + hf + hsw) ? pol : ~pol;
            e.vs  = (y >= va + vf && y < va + vf + vsw) ? pol : ~pol;
            e.von = (x < ha) && (y < va);
            e.fs  = (x == 0) && (y == 0);
            e.le  = (x == ht - 1);
        end
        return e;
    endfunction

    task automatic push(input int n);
        q_d.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        q_s.push_back(model(n, 16, 4, 6, 6, 12, 2, 2, 3, 1'b0));
        q_p.push_back(model(n, 16, 4, 6, 6, 12, 2, 2, 3, 1'b1));
    endtask

    task automatic cmp(input string tag, input int cyc, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL sb_%s cyc=%0d: got x=%0d y=%0d hs=%b vs=%b von=%b fs=%b le=%b, expected x=%0d y=%0d hs=%b vs=%b von=%b fs=%b le=%b",
                     tag, cyc, a.x, a.y, a.hs, a.vs, a.von, a.fs, a.le,
                     e.x, e.y, e.hs, e.vs, e.von, e.fs, e.le);
        end
    endtask

    // Pulse-window trackers: 0 default hsync, 1 small vsync, 2 pol vsync, 3 pol hsync.
    bit in_run[4];
    int run_len[4];
    int st_x[4];
    int st_y[4];
    int n_runs[4];

    task automatic track(input int k, input logic act, input int x, input int y,
                         input int want_len, input int want_x, input int want_y,
                         input bit chk_y, input string nm);
        if (act) begin
            if (!in_run[k]) begin
                in_run[k]  = 1'b1;
                run_len[k] = 1;
                st_x[k]    = x;
                st_y[k]    = y;
            end else begin
                run_len[k]++;
            end
        end else if (in_run[k]) begin
            in_run[k] = 1'b0;
            n_runs[k]++;
            chk({nm, "_len"}, run_len[k], want_len);
            chk({nm, "_start_x"}, st_x[k], want_x);
            if (chk_y) chk({nm, "_start_y"}, st_y[k], want_y);
        end
    endtask

    int cyc     = 0;
    int last_fs = -1;
    int le_cnt  = 0;
    int n_gaps  = 0;

    always @(negedge clk) begin
        cyc++;
        if (q_d.size() > 0) cmp("def", cyc, {d_x, d_y, d_hs, d_vs, d_von, d_fs, d_le}, q_d.pop_front());
        if (q_s.size() > 0) cmp("small", cyc, {s_x, s_y, s_hs, s_vs, s_von, s_fs, s_le}, q_s.pop_front());
        if (q_p.size() > 0) cmp("pol", cyc, {p_x, p_y, p_hs, p_vs, p_von, p_fs, p_le}, q_p.pop_front());

        if (reset) begin
            for (int k = 0; k < 4; k++) in_run[k] = 1'b0;
            last_fs = -1;
            le_cnt  = 0;
        end else begin
            track(0, ~d_hs, int'(d_x), int'(d_y), 96, 656, 0, 1'b0, "def_hsync");
            track(1, ~s_vs, int'(s_x), int'(s_y), 64, 0, 14, 1'b1, "small_vsync");
            track(2, p_vs, int'(p_x), int'(p_y), 64, 0, 14, 1'b1, "pol_vsync");
            track(3, p_hs, int'(p_x), int'(p_y), 6, 20, 0, 1'b0, "pol_hsync");
            if (s_fs) begin
                if (last_fs >= 0) begin
                    n_gaps++;
                    chk("frame_period", cyc - last_fs, 608);
                    chk("line_ends_per_frame", le_cnt, 19);
                end
                last_fs = cyc;
                le_cnt  = 0;
            end
            if (s_le) le_cnt++;
        end
    end

    initial begin
        reset = 1'b1;
        repeat (5) begin
            @(posedge clk);
            push(-1);
        end
        #2 reset = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            push(i);
        end
        // Reset mid-frame, asserted between edges; HOLD must show at the next sample.
        @(posedge clk);
        push(-1);
        #2 reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            push(-1);
        end
        #2 reset = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk);
            push(i);
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", q_d.size() + q_s.size() + q_p.size(), 0);
        chk("frame_gaps_seen", n_gaps, 4);
        chk("def_hsync_runs", n_runs[0], 2);
        chk("small_vsync_runs", n_runs[1], 4);
        chk("pol_vsync_runs", n_runs[2], 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
